// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the RV32I hazard controller: scoreboard state
// encoding, forwarding-select encoding and default register address width.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    // Forwarding select value that means "take the operand from the register file"
    localparam int unsigned FWD_SEL_RF = 0;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    function automatic int unsigned fwd_sel_w(input int unsigned stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-source forwarding priority encoder: the nearest later stage that writes
// the requested register wins; x0 is never forwarded.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned SEL_W      = fwd_sel_w(FWD_STAGES)
) (
    input  logic [REG_AW-1:0]            rs_addr_i,
    input  logic [FWD_STAGES*REG_AW-1:0] rd_addr_stg_i,
    input  logic [FWD_STAGES-1:0]        rd_write_stg_i,
    output logic [SEL_W-1:0]             sel_o
);

    logic [SEL_W-1:0] sel;

    // Walk from the farthest stage inward so the lowest matching index is the last written
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        for (int unsigned k = FWD_STAGES; k > 0; k--) begin
            if (rd_write_stg_i[k-1] &&
                (rd_addr_stg_i[(k-1)*REG_AW +: REG_AW] == rs_addr_i) &&
                (rs_addr_i != '0)) begin
                sel = SEL_W'(k);
            end
        end
    end

    assign sel_o = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside ID/EX: operand forwarding selects, load-use bubbles,
// taken-branch flushes and a one-entry scoreboard for a multi-cycle unit.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned MC_MAX     = 40
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [REG_AW-1:0]                    rs1_addr_id,
    input  logic [REG_AW-1:0]                    rs2_addr_id,
    input  logic                                 rs1_used_id,
    input  logic                                 rs2_used_id,
    input  logic [REG_AW-1:0]                    rd_addr_id,
    input  logic                                 rd_write_id,
    input  logic [REG_AW-1:0]                    rs1_addr_ex,
    input  logic [REG_AW-1:0]                    rs2_addr_ex,
    input  logic [REG_AW-1:0]                    rd_addr_ex,
    input  logic                                 rd_write_ex,
    input  logic                                 is_load_ex,
    input  logic                                 branch_taken_ex,
    input  logic                                 mc_start_ex,
    input  logic                                 mc_done,
    input  logic [FWD_STAGES*REG_AW-1:0]         rd_addr_stg,
    input  logic [FWD_STAGES-1:0]                rd_write_stg,
    output logic [fwd_sel_w(FWD_STAGES)-1:0]     fwd_sel_src1,
    output logic [fwd_sel_w(FWD_STAGES)-1:0]     fwd_sel_src2,
    output logic                                 stall_if,
    output logic                                 stall_id,
    output logic                                 flush_id,
    output logic                                 flush_ex,
    output logic                                 mc_busy,
    output logic                                 mc_timeout
);

    localparam int unsigned SEL_W = fwd_sel_w(FWD_STAGES);
    localparam int unsigned LU_W  = 2;
    localparam int unsigned WD_W  = $clog2(MC_MAX + 1);

    mc_state_e         state_q, state_d;
    logic [REG_AW-1:0] mc_rd_q, mc_rd_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
    logic              timeout_q, timeout_d;

    logic [SEL_W-1:0]  sel1, sel2;
    logic              mc_start_ok;
    logic              lu_detect, lu_active;
    logic              mc_raw, mc_waw, mc_stall;

    fwd_select #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_fwd_src1 (
        .rs_addr_i      (rs1_addr_ex),
        .rd_addr_stg_i  (rd_addr_stg),
        .rd_write_stg_i (rd_write_stg),
        .sel_o          (sel1)
    );

    fwd_select #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .SEL_W      (SEL_W)
    ) u_fwd_src2 (
        .rs_addr_i      (rs2_addr_ex),
        .rd_addr_stg_i  (rd_addr_stg),
        .rd_write_stg_i (rd_write_stg),
        .sel_o          (sel2)
    );

    // A multi-cycle issue coinciding with a taken branch is on the wrong path
    assign mc_start_ok = mc_start_ex & ~branch_taken_ex;

    assign lu_detect = is_load_ex & rd_write_ex & (rd_addr_ex != '0) &
                       ((rs1_used_id & (rs1_addr_id == rd_addr_ex)) |
                        (rs2_used_id & (rs2_addr_id == rd_addr_ex)));
    assign lu_active = lu_detect | (lu_cnt_q != '0);

    assign mc_raw   = (mc_rd_q != '0) &
                      ((rs1_used_id & (rs1_addr_id == mc_rd_q)) |
                       (rs2_used_id & (rs2_addr_id == mc_rd_q)));
    assign mc_waw   = rd_write_id & (rd_addr_id == mc_rd_q);
    assign mc_stall = (state_q == MC_BUSY) &
                      (mc_raw | mc_waw | (mc_start_ex & ~mc_done));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MC_IDLE;
            mc_rd_q   <= '0;
            wd_cnt_q  <= '0;
            lu_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_rd_q   <= mc_rd_d;
            wd_cnt_q  <= wd_cnt_d;
            lu_cnt_q  <= lu_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mc_rd_d   = mc_rd_q;
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;

        if (branch_taken_ex) begin
            lu_cnt_d = '0;
        end else if (lu_cnt_q != '0) begin
            lu_cnt_d = lu_cnt_q - LU_W'(1);
        end else if (lu_detect) begin
            lu_cnt_d = LU_W'(LOAD_LAT - 1);
        end else begin
            lu_cnt_d = '0;
        end

        case (state_q)
            MC_IDLE: begin
                if (mc_start_ok) begin
                    state_d  = MC_BUSY;
                    mc_rd_d  = rd_addr_ex;
                    wd_cnt_d = '0;
                end
            end
            MC_BUSY: begin
                // Completion takes priority over the watchdog; a same-cycle issue re-arms
                if (mc_done) begin
                    if (mc_start_ok) begin
                        mc_rd_d  = rd_addr_ex;
                        wd_cnt_d = '0;
                    end else begin
                        state_d = MC_IDLE;
                    end
                end else if (wd_cnt_q == WD_W'(MC_MAX - 1)) begin
                    state_d   = MC_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
        endcase
    end

    // Outputs are held low combinationally while reset is asserted
    always_comb begin
        fwd_sel_src1 = '0;
        fwd_sel_src2 = '0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        mc_busy      = 1'b0;
        mc_timeout   = 1'b0;
        if (rst_n) begin
            fwd_sel_src1 = sel1;
            fwd_sel_src2 = sel2;
            mc_busy      = (state_q == MC_BUSY);
            mc_timeout   = timeout_q;
            if (branch_taken_ex) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (lu_active || mc_stall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    a_no_mc_on_branch: assert property (@(posedge clk) disable iff (!rst_n)
        !(mc_start_ex && branch_taken_ex));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with an expectation queue.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned NS = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr_id, rs2_addr_id, rd_addr_id;
    logic            rs1_used_id, rs2_used_id, rd_write_id;
    logic [AW-1:0]   rs1_addr_ex, rs2_addr_ex, rd_addr_ex;
    logic            rd_write_ex, is_load_ex, branch_taken_ex, mc_start_ex, mc_done;
    logic [NS*AW-1:0] rd_addr_stg;
    logic [NS-1:0]   rd_write_stg;
    logic [1:0]      fwd_sel_src1, fwd_sel_src2;
    logic            stall_if, stall_id, flush_id, flush_ex, mc_busy, mc_timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;
    exp_t sb[$];

    logic [9:0] obs;
    assign obs = {fwd_sel_src1, fwd_sel_src2, stall_if, stall_id,
                  flush_id, flush_ex, mc_busy, mc_timeout};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW     (AW),
        .FWD_STAGES (NS),
        .LOAD_LAT   (2),
        .MC_MAX     (40)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rs1_addr_id     (rs1_addr_id),
        .rs2_addr_id     (rs2_addr_id),
        .rs1_used_id     (rs1_used_id),
        .rs2_used_id     (rs2_used_id),
        .rd_addr_id      (rd_addr_id),
        .rd_write_id     (rd_write_id),
        .rs1_addr_ex     (rs1_addr_ex),
        .rs2_addr_ex     (rs2_addr_ex),
        .rd_addr_ex      (rd_addr_ex),
        .rd_write_ex     (rd_write_ex),
        .is_load_ex      (is_load_ex),
        .branch_taken_ex (branch_taken_ex),
        .mc_start_ex     (mc_start_ex),
        .mc_done         (mc_done),
        .rd_addr_stg     (rd_addr_stg),
        .rd_write_stg    (rd_write_stg),
        .fwd_sel_src1    (fwd_sel_src1),
        .fwd_sel_src2    (fwd_sel_src2),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex),
        .mc_busy         (mc_busy),
        .mc_timeout      (mc_timeout)
    );

    // Expected vector: {src1, src2, stall_if, stall_id, flush_id, flush_ex, busy, timeout}
    function automatic logic [9:0] mk(input logic [1:0] f1, input logic [1:0] f2,
                                      input logic st, input logic fid, input logic fex,
                                      input logic bz, input logic to);
        return {f1, f2, st, st, fid, fex, bz, to};
    endfunction

    task automatic push(input string tag, input logic [9:0] e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic compare();
        exp_t item;
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", item.tag, obs, item.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [9:0] e);
        push(tag, e);
        compare();
    endtask

    task automatic clr();
        rs1_addr_id = '0; rs2_addr_id = '0; rd_addr_id = '0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; rd_write_id = 1'b0;
        rs1_addr_ex = '0; rs2_addr_ex = '0; rd_addr_ex = '0;
        rd_write_ex = 1'b0; is_load_ex = 1'b0; branch_taken_ex = 1'b0;
        mc_start_ex = 1'b0; mc_done = 1'b0;
        rd_addr_stg = '0; rd_write_stg = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        clr();
        rst_n = 1'b0;
        // Inputs that would otherwise forward and flush, held during reset
        rs1_addr_ex = 5'd5; rd_addr_stg = {5'd5, 5'd5}; rd_write_stg = 2'b11;
        branch_taken_ex = 1'b1;
        #2;
        chk("reset_outputs", mk(0, 0, 0, 0, 0, 0, 0));
        nxt();
        rst_n = 1'b1;
        clr();

        // Forwarding priority
        nxt(); clr();
        rd_addr_stg = {5'd5, 5'd5}; rd_write_stg = 2'b11; rs1_addr_ex = 5'd5;
        chk("fwd_mem_wins", mk(1, 0, 0, 0, 0, 0, 0));
        rd_write_stg = 2'b10;
        chk("fwd_wb_only", mk(2, 0, 0, 0, 0, 0, 0));
        rs1_addr_ex = 5'd0; rd_addr_stg = {5'd0, 5'd0}; rd_write_stg = 2'b11;
        chk("fwd_x0", mk(0, 0, 0, 0, 0, 0, 0));
        rd_addr_stg = {5'd9, 5'd3}; rs1_addr_ex = 5'd3; rs2_addr_ex = 5'd9;
        chk("fwd_both_src", mk(1, 2, 0, 0, 0, 0, 0));
        rd_write_stg = 2'b01;
        chk("fwd_wb_disabled", mk(1, 0, 0, 0, 0, 0, 0));

        // Load-use on rs1, LOAD_LAT=2
        nxt(); clr();
        is_load_ex = 1'b1; rd_write_ex = 1'b1; rd_addr_ex = 5'd6;
        rs1_used_id = 1'b1; rs1_addr_id = 5'd6;
        chk("lu_detect", mk(0, 0, 1, 0, 1, 0, 0));
        nxt();
        is_load_ex = 1'b0; rd_write_ex = 1'b0; rd_addr_ex = 5'd0;
        chk("lu_second", mk(0, 0, 1, 0, 1, 0, 0));
        nxt();
        chk("lu_release", mk(0, 0, 0, 0, 0, 0, 0));

        // Load-use gating by source-used flag and x0
        nxt(); clr();
        is_load_ex = 1'b1; rd_write_ex = 1'b1; rd_addr_ex = 5'd6;
        rs1_addr_id = 5'd6;
        chk("lu_unused_src", mk(0, 0, 0, 0, 0, 0, 0));
        rd_addr_ex = 5'd0; rs1_addr_id = 5'd0; rs1_used_id = 1'b1;
        chk("lu_x0", mk(0, 0, 0, 0, 0, 0, 0));
        rd_addr_ex = 5'd6; rs1_used_id = 1'b0; rs2_used_id = 1'b1; rs2_addr_id = 5'd6;
        chk("lu_rs2_detect", mk(0, 0, 1, 0, 1, 0, 0));
        nxt();
        is_load_ex = 1'b0; rd_write_ex = 1'b0; rd_addr_ex = 5'd0;
        chk("lu_rs2_second", mk(0, 0, 1, 0, 1, 0, 0));
        nxt();
        chk("lu_rs2_release", mk(0, 0, 0, 0, 0, 0, 0));

        // Branch overrides a load-use stall and clears the bubble counter
        nxt(); clr();
        is_load_ex = 1'b1; rd_write_ex = 1'b1; rd_addr_ex = 5'd6;
        rs1_used_id = 1'b1; rs1_addr_id = 5'd6; branch_taken_ex = 1'b1;
        chk("br_override", mk(0, 0, 0, 1, 1, 0, 0));
        nxt();
        is_load_ex = 1'b0; rd_write_ex = 1'b0; rd_addr_ex = 5'd0; branch_taken_ex = 1'b0;
        chk("br_after", mk(0, 0, 0, 0, 0, 0, 0));

        // Multi-cycle RAW: div x7
        nxt(); clr();
        mc_start_ex = 1'b1; rd_addr_ex = 5'd7; rd_write_ex = 1'b1;
        chk("mc_issue", mk(0, 0, 0, 0, 0, 0, 0));
        nxt(); clr();
        rs1_used_id = 1'b1; rs1_addr_id = 5'd7;
        chk("mc_raw", mk(0, 0, 1, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("mc_raw_hold", mk(0, 0, 1, 0, 1, 1, 0));
        end
        nxt();
        mc_done = 1'b1;
        chk("mc_done_cycle", mk(0, 0, 1, 0, 1, 1, 0));
        nxt();
        mc_done = 1'b0;
        chk("mc_release", mk(0, 0, 0, 0, 0, 0, 0));

        // WAW, independent instruction, same-cycle re-arm
        nxt(); clr();
        mc_start_ex = 1'b1; rd_addr_ex = 5'd8; rd_write_ex = 1'b1;
        nxt(); clr();
        rd_write_id = 1'b1; rd_addr_id = 5'd8;
        chk("mc_waw", mk(0, 0, 1, 0, 1, 1, 0));
        rd_addr_id = 5'd9; rs1_used_id = 1'b1; rs1_addr_id = 5'd3;
        chk("mc_indep", mk(0, 0, 0, 0, 0, 1, 0));
        nxt();
        mc_done = 1'b1; mc_start_ex = 1'b1; rd_addr_ex = 5'd10; rd_write_ex = 1'b1;
        chk("mc_rearm_cycle", mk(0, 0, 0, 0, 0, 1, 0));
        nxt(); clr();
        rs2_used_id = 1'b1; rs2_addr_id = 5'd10;
        chk("mc_rearm_raw", mk(0, 0, 1, 0, 1, 1, 0));
        rs2_addr_id = 5'd8;
        chk("mc_old_rd_free", mk(0, 0, 0, 0, 0, 1, 0));
        nxt();
        mc_done = 1'b1;
        nxt();
        mc_done = 1'b0;
        chk("mc_idle_again", mk(0, 0, 0, 0, 0, 0, 0));

        // Watchdog: no completion for MC_MAX cycles
        nxt(); clr();
        mc_start_ex = 1'b1; rd_addr_ex = 5'd11; rd_write_ex = 1'b1;
        nxt(); clr();
        rs1_used_id = 1'b1; rs1_addr_id = 5'd3;
        for (int i = 0; i < 40; i++) begin
            chk("wd_busy", mk(0, 0, 0, 0, 0, 1, 0));
            nxt();
        end
        chk("wd_timeout", mk(0, 0, 0, 0, 0, 0, 1));
        rs1_addr_id = 5'd11;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("wd_sticky", mk(0, 0, 0, 0, 0, 0, 1));
        end

        // Asynchronous reset while BUSY
        nxt(); clr();
        mc_start_ex = 1'b1; rd_addr_ex = 5'd12; rd_write_ex = 1'b1;
        nxt(); clr();
        rs1_used_id = 1'b1; rs1_addr_id = 5'd12;
        rd_addr_stg = {5'd0, 5'd4}; rd_write_stg = 2'b01; rs2_addr_ex = 5'd4;
        chk("rst_pre", mk(0, 1, 1, 0, 1, 1, 1));
        #1;
        rst_n = 1'b0;
        chk("rst_async", mk(0, 0, 0, 0, 0, 0, 0));
        nxt();
        rst_n = 1'b1;
        rd_write_stg = 2'b00;
        chk("rst_after", mk(0, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
